// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell with a registered borrow loop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0] cnt;
    logic borrow_reg, d, bnext, last, accept;
    always_comb begin
        d      = a_sh[0] ^ b_sh[0] ^ borrow_reg;
        bnext  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow_reg) | (b_sh[0] & borrow_reg);
        last   = cnt == CW'(WIDTH - 1);
        accept = start && state != SHIFT;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? SHIFT : IDLE;
            SHIFT:   nxt = last ? DONE : SHIFT;
            DONE:    nxt = start ? SHIFT : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy = state == SHIFT;
        done = state == DONE;
    end
    // diff/borrow_out are only written on the completing shift so partials never leak out
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            borrow_reg <= bin;
            cnt        <= '0;
        end else if (state == SHIFT) begin
            r_sh       <= {d, r_sh[WIDTH-1:1]};
            a_sh       <= a_sh >> 1;
            b_sh       <= b_sh >> 1;
            borrow_reg <= bnext;
            cnt        <= last ? '0 : cnt + 1'b1;
            if (last) begin
                diff       <= {d, r_sh[WIDTH-1:1]};
                borrow_out <= bnext;
            end
        end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor at WIDTH=8 plus an exhaustive WIDTH=3 sweep
module tb_serial_subtractor;
    logic clk, rst_n;
    logic start, bin, busy, done, bo;
    logic [7:0] a, b, diff;
    logic start3, bin3, busy3, done3, bo3;
    logic [2:0] a3, b3, diff3;
    int passed, total;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .borrow_out(bo)
    );
    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          output int lat, output int busy_cyc, output logic partial);
        logic [7:0] old;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1;
        old = diff;
        lat = -1; busy_cyc = 0; partial = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 0;
            if (busy) busy_cyc++;
            if (!done && diff !== old) partial = 1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #12;
        total++; if (busy !== 0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (diff !== 8'h00) $display("FAIL reset_diff: got %h expected 00", diff); else passed++;
        total++; if (bo !== 0) $display("FAIL reset_borrow: got %b expected 0", bo); else passed++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic;
        int lat, bc;
        logic p;
        run_op(8'h35, 8'h12, 1'b0, lat, bc, p);
        total++; if (lat !== 9) $display("FAIL basic_latency: got %0d expected 9", lat); else passed++;
        total++; if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", bc); else passed++;
        total++; if (p !== 0) $display("FAIL basic_no_partial: got %b expected 0", p); else passed++;
        total++; if (diff !== 8'h23) $display("FAIL basic_diff: got %h expected 23", diff); else passed++;
        total++; if (bo !== 0) $display("FAIL basic_borrow: got %b expected 0", bo); else passed++;
        @(negedge clk);
        total++; if (done !== 0) $display("FAIL basic_done_pulse: got %b expected 0", done); else passed++;
    endtask

    task automatic test_underflow;
        int lat, bc;
        logic p;
        run_op(8'h00, 8'h01, 1'b0, lat, bc, p);
        total++; if (diff !== 8'hFF || bo !== 1) $display("FAIL uf_00_01: got %h/%b expected ff/1", diff, bo); else passed++;
        total++; if (lat !== 9) $display("FAIL uf_00_01_latency: got %0d expected 9", lat); else passed++;
        run_op(8'hFF, 8'hFF, 1'b1, lat, bc, p);
        total++; if (diff !== 8'hFF || bo !== 1) $display("FAIL uf_ff_ff_1: got %h/%b expected ff/1", diff, bo); else passed++;
        total++; if (p !== 0) $display("FAIL uf_ff_ff_1_partial: got %b expected 0", p); else passed++;
        run_op(8'h10, 8'h05, 1'b1, lat, bc, p);
        total++; if (diff !== 8'h0A || bo !== 0) $display("FAIL bin_10_05_1: got %h/%b expected 0a/0", diff, bo); else passed++;
        run_op(8'h80, 8'h7F, 1'b1, lat, bc, p);
        total++; if (diff !== 8'h00 || bo !== 0) $display("FAIL bin_80_7f_1: got %h/%b expected 00/0", diff, bo); else passed++;
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 0; start = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 1) start = 0;
            if (i == 3) begin
                a = 8'h99; b = 8'h00; bin = 1; start = 1;
            end
            if (i == 4) start = 0;
        end
        total++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d expected 1", dones); else passed++;
        total++; if (diff !== 8'h23 || bo !== 0) $display("FAIL ignore_result: got %h/%b expected 23/0", diff, bo); else passed++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 0; start = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 0;
        end
        total++; if (busy !== 1) $display("FAIL mid_busy_before: got %b expected 1", busy); else passed++;
        rst_n = 0;
        #1;
        total++; if (busy !== 0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 0) $display("FAIL mid_done: got %b expected 0", done); else passed++;
        total++; if (diff !== 8'h00) $display("FAIL mid_diff: got %h expected 00", diff); else passed++;
        total++; if (bo !== 0) $display("FAIL mid_borrow: got %b expected 0", bo); else passed++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++; if (dones !== 0) $display("FAIL mid_no_done: got %0d expected 0", dones); else passed++;
        total++; if (busy !== 0 || diff !== 8'h00) $display("FAIL mid_idle: got busy %b diff %h expected 0/00", busy, diff); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4], vb [4], vd [4];
        logic vbin [4], vbo [4];
        int n = 0, prev = 0;
        logic got;
        va = '{8'h35, 8'h00, 8'h80, 8'h12};
        vb = '{8'h12, 8'h01, 8'h7F, 8'h34};
        vbin = '{1'b0, 1'b0, 1'b1, 1'b0};
        vd = '{8'h23, 8'hFF, 8'h00, 8'hDE};
        vbo = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        a = va[0]; b = vb[0]; bin = vbin[0]; start = 1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                n++;
                if (done) begin
                    got = 1;
                    break;
                end
            end
            total++;
            if (!got) $display("FAIL b2b_timeout op %0d: got no done expected done", k);
            else if (diff !== vd[k] || bo !== vbo[k]) $display("FAIL b2b_result op %0d: got %h/%b expected %h/%b", k, diff, bo, vd[k], vbo[k]);
            else passed++;
            if (k > 0) begin
                total++; if (n - prev !== 9) $display("FAIL b2b_interval op %0d: got %0d expected 9", k, n - prev); else passed++;
            end
            prev = n;
            if (k < 3) begin
                a = va[k+1]; b = vb[k+1]; bin = vbin[k+1];
            end else start = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_width3;
        logic [3:0] ref_v;
        logic got;
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            a3 = i[6:4]; b3 = i[3:1]; bin3 = i[0]; start3 = 1;
            ref_v = {1'b0, a3} - {1'b0, b3} - {3'b000, bin3};
            got = 0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                start3 = 0;
                if (done3) begin
                    got = 1;
                    break;
                end
            end
            total++;
            if (!got) $display("FAIL w3_timeout %0d-%0d-%0d: got no done expected done", a3, b3, bin3);
            else if ({bo3, diff3} !== ref_v) $display("FAIL w3 %0d-%0d-%0d: got %b/%h expected %b/%h", a3, b3, bin3, bo3, diff3, ref_v[3], ref_v[2:0]);
            else passed++;
        end
    endtask

    initial begin
        passed = 0; total = 0;
        start = 0; a = 0; b = 0; bin = 0;
        start3 = 0; a3 = 0; b3 = 0; bin3 = 0;
        test_reset;
        test_basic;
        test_underflow;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_width3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
